// File: rtl/axil_wr_buffer_pkg.sv
// Shared helpers for the AXI4-Lite write buffer: outstanding-count arithmetic.
package axil_wr_buffer_pkg;

    // Widest outstanding counter ever needed (limit is at most 15).
    localparam int CNT_MAX_W = 4;

    // One step of an outstanding counter: +1 on issue, -1 on response,
    // unchanged when both happen, and never wraps below zero.
    function automatic logic [CNT_MAX_W-1:0] cnt_step(
        input logic [CNT_MAX_W-1:0] cnt,
        input logic                 inc,
        input logic                 dec
    );
        logic [CNT_MAX_W-1:0] r;
        r = cnt;
        if (inc && !dec) begin
            r = cnt + CNT_MAX_W'(1);
        end else if (dec && !inc && cnt != '0) begin
            r = cnt - CNT_MAX_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/axil_wr_fifo.sv
// Generic synchronous FIFO with registered full/empty flags and a
// valid/ready output whose payload is held until it is popped.
// Both flags come out of reset set, so the FIFO neither accepts nor
// offers anything while rst is high.
module axil_wr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             full_q;
    logic             empty_q;
    logic             push;
    logic             pop;

    assign push      = in_valid && !full_q;
    assign pop       = out_ready && !empty_q;
    assign in_ready  = !full_q;
    assign out_valid = !empty_q;
    assign out_data  = mem[rd_ptr];

    // Occupancy after this cycle's push/pop; drives the registered flags.
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    // Pointers, occupancy and flags; reset flushes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b1;
            empty_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count   <= count_nxt;
            full_q  <= (count_nxt == CW'(DEPTH));
            empty_q <= (count_nxt == '0);
        end
    end

    // Payload storage; contents are meaningless until flagged valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: rtl/axil_wr_buffer.sv
// AXI4-Lite write-path buffer: independent AW and W FIFOs, a bounded
// number of writes in flight downstream, and a 2-entry B skid buffer.
module axil_wr_buffer #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int AW_DEPTH        = 4,
    parameter int W_DEPTH         = 4,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [CNT_W-1:0]      outstanding,
    output logic                  b_unexpected
);

    import axil_wr_buffer_pkg::*;

    logic [CNT_W-1:0]               aw_cnt;
    logic [CNT_W-1:0]               w_cnt;
    logic                           aw_below;
    logic                           w_below;
    logic                           aw_fifo_valid;
    logic                           w_fifo_valid;
    logic [ADDR_WIDTH+2:0]          aw_fifo_data;
    logic [STRB_WIDTH+DATA_WIDTH-1:0] w_fifo_data;
    logic                           aw_hs;
    logic                           w_hs;
    logic                           b_hs;

    // Issue is gated only by registered state, never by a ready input, so
    // a raised valid cannot drop before its handshake.
    assign aw_below       = (aw_cnt < CNT_W'(MAX_OUTSTANDING));
    assign w_below        = (w_cnt < CNT_W'(MAX_OUTSTANDING));
    assign m_axil_awvalid = aw_fifo_valid && aw_below;
    assign m_axil_wvalid  = w_fifo_valid && w_below;
    assign aw_hs          = m_axil_awvalid && m_axil_awready;
    assign w_hs           = m_axil_wvalid && m_axil_wready;
    assign b_hs           = m_axil_bvalid && m_axil_bready;
    assign outstanding    = aw_cnt;

    assign {m_axil_awprot, m_axil_awaddr} = aw_fifo_data;
    assign {m_axil_wstrb, m_axil_wdata}   = w_fifo_data;

    axil_wr_fifo #(.WIDTH(ADDR_WIDTH + 3), .DEPTH(AW_DEPTH)) u_aw_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_data   ({s_axil_awprot, s_axil_awaddr}),
        .in_valid  (s_axil_awvalid),
        .in_ready  (s_axil_awready),
        .out_data  (aw_fifo_data),
        .out_valid (aw_fifo_valid),
        .out_ready (m_axil_awready && aw_below)
    );

    axil_wr_fifo #(.WIDTH(STRB_WIDTH + DATA_WIDTH), .DEPTH(W_DEPTH)) u_w_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_data   ({s_axil_wstrb, s_axil_wdata}),
        .in_valid  (s_axil_wvalid),
        .in_ready  (s_axil_wready),
        .out_data  (w_fifo_data),
        .out_valid (w_fifo_valid),
        .out_ready (m_axil_wready && w_below)
    );

    // Two entries let a response be taken every cycle with a registered ready.
    axil_wr_fifo #(.WIDTH(2), .DEPTH(2)) u_b_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (m_axil_bresp),
        .in_valid  (m_axil_bvalid),
        .in_ready  (m_axil_bready),
        .out_data  (s_axil_bresp),
        .out_valid (s_axil_bvalid),
        .out_ready (s_axil_bready)
    );

    // Outstanding counters and the sticky flag for responses with nothing in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_cnt       <= '0;
            w_cnt        <= '0;
            b_unexpected <= 1'b0;
        end else begin
            aw_cnt <= CNT_W'(cnt_step(CNT_MAX_W'(aw_cnt), aw_hs, b_hs));
            w_cnt  <= CNT_W'(cnt_step(CNT_MAX_W'(w_cnt), w_hs, b_hs));
            if (b_hs && aw_cnt == '0 && w_cnt == '0) begin
                b_unexpected <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axil_wr_buffer.sv
// Self-checking bench for axil_wr_buffer: directed scenarios followed by
// randomized traffic compared against a queue-based reference model.
module tb_axil_wr_buffer;

    localparam int DW    = 32;
    localparam int AWID  = 32;
    localparam int SW    = DW / 8;
    localparam int AWD   = 4;
    localparam int WD    = 4;
    localparam int MAXO  = 2;
    localparam int CNT_W = $clog2(MAXO + 1);

    logic            clk;
    logic            rst;
    logic [AWID-1:0] s_axil_awaddr;
    logic [2:0]      s_axil_awprot;
    logic            s_axil_awvalid;
    logic            s_axil_awready;
    logic [DW-1:0]   s_axil_wdata;
    logic [SW-1:0]   s_axil_wstrb;
    logic            s_axil_wvalid;
    logic            s_axil_wready;
    logic [1:0]      s_axil_bresp;
    logic            s_axil_bvalid;
    logic            s_axil_bready;
    logic [AWID-1:0] m_axil_awaddr;
    logic [2:0]      m_axil_awprot;
    logic            m_axil_awvalid;
    logic            m_axil_awready;
    logic [DW-1:0]   m_axil_wdata;
    logic [SW-1:0]   m_axil_wstrb;
    logic            m_axil_wvalid;
    logic            m_axil_wready;
    logic [1:0]      m_axil_bresp;
    logic            m_axil_bvalid;
    logic            m_axil_bready;
    logic [CNT_W-1:0] outstanding;
    logic            b_unexpected;

    int n_checks = 0;
    int n_errors = 0;

    axil_wr_buffer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AWID), .STRB_WIDTH(SW),
        .AW_DEPTH(AWD), .W_DEPTH(WD), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
        .m_axil_bready(m_axil_bready),
        .outstanding(outstanding), .b_unexpected(b_unexpected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        m_axil_bvalid  = 1'b0; m_axil_bresp  = 2'b00;
        m_axil_awready = 1'b1; m_axil_wready = 1'b1;
        s_axil_bready  = 1'b1;
    endtask

    // Randomized traffic against an abstract model: occupancy = accepted - issued,
    // in-flight = issued - responded, responses forwarded in arrival order.
    task automatic run_random(input int n, input int w_lead);
        logic [34:0] aw_q[$];
        logic [35:0] w_q[$];
        logic [1:0]  bq[$];
        int aw_occ = 0, w_occ = 0, cnt_aw = 0, cnt_w = 0;
        int aw_sent = 0, w_sent = 0, sl_aw = 0, sl_w = 0, sl_b = 0, cyc = 0;
        logic u_aw, u_w, u_b, d_aw, d_w, d_b;
        while ((sl_b < n || bq.size() != 0) && cyc < 4000) begin
            check("rnd_awready", s_axil_awready, aw_occ != AWD);
            check("rnd_wready", s_axil_wready, w_occ != WD);
            check("rnd_awvalid", m_axil_awvalid, aw_occ > 0 && cnt_aw < MAXO);
            check("rnd_wvalid", m_axil_wvalid, w_occ > 0 && cnt_w < MAXO);
            check("rnd_outstanding", outstanding, cnt_aw);
            check("rnd_bready", m_axil_bready, bq.size() < 2);
            check("rnd_bvalid", s_axil_bvalid, bq.size() > 0);
            if (m_axil_awvalid && aw_q.size() > 0)
                check("rnd_aw_payload", {m_axil_awprot, m_axil_awaddr}, aw_q[0]);
            if (m_axil_wvalid && w_q.size() > 0)
                check("rnd_w_payload", {m_axil_wstrb, m_axil_wdata}, w_q[0]);
            if (s_axil_bvalid && bq.size() > 0)
                check("rnd_bresp", s_axil_bresp, bq[0]);

            if (!s_axil_awvalid && aw_sent < n && w_sent >= w_lead && $urandom_range(0, 3) != 0) begin
                s_axil_awvalid = 1'b1;
                s_axil_awaddr  = $urandom;
                s_axil_awprot  = 3'($urandom_range(0, 7));
            end
            if (!s_axil_wvalid && w_sent < n && $urandom_range(0, 3) != 0) begin
                s_axil_wvalid = 1'b1;
                s_axil_wdata  = $urandom;
                s_axil_wstrb  = 4'($urandom_range(0, 15));
            end
            m_axil_awready = ($urandom_range(0, 2) != 0);
            m_axil_wready  = ($urandom_range(0, 2) != 0);
            s_axil_bready  = ($urandom_range(0, 2) != 0);
            if (!m_axil_bvalid && sl_aw > sl_b && sl_w > sl_b && $urandom_range(0, 1) != 0) begin
                m_axil_bvalid = 1'b1;
                m_axil_bresp  = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
            end

            u_aw = s_axil_awvalid && s_axil_awready;
            u_w  = s_axil_wvalid && s_axil_wready;
            d_aw = m_axil_awvalid && m_axil_awready;
            d_w  = m_axil_wvalid && m_axil_wready;
            d_b  = m_axil_bvalid && m_axil_bready;
            u_b  = s_axil_bvalid && s_axil_bready;
            tick();

            if (u_aw) begin
                aw_q.push_back({s_axil_awprot, s_axil_awaddr});
                aw_occ++; aw_sent++; s_axil_awvalid = 1'b0;
            end
            if (u_w) begin
                w_q.push_back({s_axil_wstrb, s_axil_wdata});
                w_occ++; w_sent++; s_axil_wvalid = 1'b0;
            end
            if (d_aw) begin
                void'(aw_q.pop_front()); aw_occ--; cnt_aw++; sl_aw++;
            end
            if (d_w) begin
                void'(w_q.pop_front()); w_occ--; cnt_w++; sl_w++;
            end
            if (u_b) void'(bq.pop_front());
            if (d_b) begin
                bq.push_back(m_axil_bresp);
                cnt_aw--; cnt_w--; sl_b++;
                m_axil_bvalid = 1'b0;
            end
            cyc++;
        end
        check("rnd_all_responses", sl_b, n);
        check("rnd_no_unexpected", b_unexpected, 1'b0);
        idle_inputs();
        tick();
    endtask

    initial begin
        int got, sent, hs, c;
        logic hs_up, hs_dn;

        rst = 1'b1;
        s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_wdata = '0; s_axil_wstrb = '0;
        idle_inputs();
        s_axil_bready = 1'b0;
        repeat (2) tick();
        check("rst_awready", s_axil_awready, 1'b0);
        check("rst_wready", s_axil_wready, 1'b0);
        check("rst_bvalid", s_axil_bvalid, 1'b0);
        check("rst_m_awvalid", m_axil_awvalid, 1'b0);
        check("rst_m_wvalid", m_axil_wvalid, 1'b0);
        check("rst_m_bready", m_axil_bready, 1'b0);
        rst = 1'b0;
        tick();
        check("post_awready", s_axil_awready, 1'b1);
        check("post_wready", s_axil_wready, 1'b1);
        check("post_m_bready", m_axil_bready, 1'b1);
        check("post_outstanding", outstanding, 0);
        check("post_unexpected", b_unexpected, 1'b0);

        // Single write with downstream always ready.
        s_axil_awvalid = 1'b1; s_axil_awaddr = 32'h10; s_axil_awprot = 3'd0;
        s_axil_wvalid  = 1'b1; s_axil_wdata = 32'hDEADBEEF; s_axil_wstrb = 4'hF;
        tick();
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        check("single_awvalid", m_axil_awvalid, 1'b1);
        check("single_awaddr", m_axil_awaddr, 32'h10);
        check("single_wvalid", m_axil_wvalid, 1'b1);
        check("single_wdata", m_axil_wdata, 32'hDEADBEEF);
        check("single_wstrb", m_axil_wstrb, 4'hF);
        tick();
        check("single_outstanding1", outstanding, 1);
        check("single_awvalid_low", m_axil_awvalid, 1'b0);
        m_axil_bvalid = 1'b1; m_axil_bresp = 2'b00; s_axil_bready = 1'b0;
        tick();
        m_axil_bvalid = 1'b0;
        check("single_bvalid", s_axil_bvalid, 1'b1);
        check("single_bresp", s_axil_bresp, 2'b00);
        check("single_outstanding0", outstanding, 0);
        s_axil_bready = 1'b1;
        tick();
        check("single_b_done", s_axil_bvalid, 1'b0);

        // Fill the AW FIFO with downstream stalled, then drain in order.
        m_axil_awready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_axil_awvalid = 1'b1; s_axil_awaddr = 32'h100 + 32'(4 * i);
            check("fill_ready", s_axil_awready, 1'b1);
            tick();
        end
        s_axil_awaddr = 32'h110;
        check("fill_full", s_axil_awready, 1'b0);
        tick();
        check("fill_still_full", s_axil_awready, 1'b0);
        m_axil_awready = 1'b1;
        got = 0; sent = 4; c = 0;
        while (got < 6 && c < 60) begin
            m_axil_bvalid = (outstanding != 0); m_axil_bresp = 2'b00;
            hs_up = s_axil_awvalid && s_axil_awready;
            hs_dn = m_axil_awvalid && m_axil_awready;
            if (hs_dn) check("fill_addr", m_axil_awaddr, 32'h100 + 32'(4 * got));
            tick();
            if (hs_dn) got++;
            if (hs_up) begin
                sent++;
                if (sent < 6) s_axil_awaddr = 32'h100 + 32'(4 * sent);
                else s_axil_awvalid = 1'b0;
            end
            c++;
        end
        check("fill_drained", got, 6);
        c = 0;
        while (outstanding != 0 && c < 10) begin
            m_axil_bvalid = 1'b1;
            tick();
            c++;
        end
        m_axil_bvalid = 1'b0;
        repeat (2) tick();

        // Outstanding limit of 2 with responses withheld.
        hs = 0; sent = 0;
        s_axil_awvalid = 1'b1; s_axil_awaddr = 32'h200;
        for (int i = 0; i < 10; i++) begin
            hs_dn = m_axil_awvalid && m_axil_awready;
            hs_up = s_axil_awvalid && s_axil_awready;
            tick();
            if (hs_dn) hs++;
            if (hs_up) begin
                sent++;
                if (sent < 3) s_axil_awaddr = 32'h200 + 32'(4 * sent);
                else s_axil_awvalid = 1'b0;
            end
        end
        check("limit_handshakes", hs, 2);
        check("limit_sent", sent, 3);
        check("limit_outstanding", outstanding, 2);
        check("limit_awvalid_held", m_axil_awvalid, 1'b0);
        check("limit_bready", m_axil_bready, 1'b1);
        m_axil_bvalid = 1'b1; m_axil_bresp = 2'b10; s_axil_bready = 1'b0;
        tick();
        m_axil_bvalid = 1'b0;
        check("limit_awvalid_up", m_axil_awvalid, 1'b1);
        check("limit_third_addr", m_axil_awaddr, 32'h208);
        check("limit_bvalid", s_axil_bvalid, 1'b1);
        check("limit_bresp_slverr", s_axil_bresp, 2'b10);
        check("limit_outstanding1", outstanding, 1);
        s_axil_bready = 1'b1;
        tick();
        check("limit_outstanding2", outstanding, 2);
        check("limit_b_done", s_axil_bvalid, 1'b0);

        // Simultaneous issue and response at one outstanding, then a stray B.
        m_axil_bvalid = 1'b1; m_axil_bresp = 2'b00;
        tick();
        m_axil_bvalid = 1'b0;
        check("simul_pre", outstanding, 1);
        s_axil_awvalid = 1'b1; s_axil_awaddr = 32'h300;
        tick();
        s_axil_awvalid = 1'b0;
        check("simul_awvalid", m_axil_awvalid, 1'b1);
        m_axil_bvalid = 1'b1;
        tick();
        m_axil_bvalid = 1'b0;
        check("simul_outstanding", outstanding, 1);
        m_axil_bvalid = 1'b1;
        tick();
        m_axil_bvalid = 1'b0;
        check("stray_pre_count", outstanding, 0);
        check("stray_pre_flag", b_unexpected, 1'b0);
        tick();
        s_axil_bready = 1'b0;
        m_axil_bvalid = 1'b1; m_axil_bresp = 2'b10;
        tick();
        m_axil_bvalid = 1'b0;
        check("stray_flag", b_unexpected, 1'b1);
        check("stray_count", outstanding, 0);
        check("stray_forwarded", s_axil_bvalid, 1'b1);
        check("stray_bresp", s_axil_bresp, 2'b10);
        s_axil_bready = 1'b1;
        tick();
        tick();
        check("stray_sticky", b_unexpected, 1'b1);

        // Reset with writes buffered: everything is dropped.
        m_axil_awready = 1'b0; m_axil_wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_axil_awvalid = 1'b1; s_axil_awaddr = 32'h400 + 32'(4 * i);
            s_axil_wvalid  = 1'b1; s_axil_wdata = 32'hA000 + 32'(i);
            tick();
        end
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        check("flush_pre_awvalid", m_axil_awvalid, 1'b1);
        rst = 1'b1;
        tick();
        check("flush_rst_awvalid", m_axil_awvalid, 1'b0);
        check("flush_rst_wvalid", m_axil_wvalid, 1'b0);
        check("flush_rst_bvalid", s_axil_bvalid, 1'b0);
        check("flush_rst_awready", s_axil_awready, 1'b0);
        rst = 1'b0;
        tick();
        check("flush_awready", s_axil_awready, 1'b1);
        check("flush_wready", s_axil_wready, 1'b1);
        check("flush_bready", m_axil_bready, 1'b1);
        check("flush_outstanding", outstanding, 0);
        check("flush_unexpected", b_unexpected, 1'b0);
        m_axil_awready = 1'b1; m_axil_wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("flush_no_awvalid", m_axil_awvalid, 1'b0);
            check("flush_no_wvalid", m_axil_wvalid, 1'b0);
            check("flush_no_b", s_axil_bvalid, 1'b0);
            tick();
        end

        // W leads AW by three beats, then free-running random traffic.
        idle_inputs();
        run_random(40, 3);
        run_random(150, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
